dot_product_pe: RTL
===================

Name: dot_product_pe

Overview:
- Next-generation dot-product processing element: multi-lane, handshaked, len-programmable, with selectable saturate/truncate output.
- Captures two signed vectors on a start handshake and reduces LANES products per cycle into a wide signed accumulator.
- Presents a WORD_SIZE result under valid/ready back-pressure.
- Sits between the vector register file and the result write-back path of the vector processor.

Parameters:
- NO_OF_ELEM, 16, maximum elements per vector; power of 2, >= LANES.
- WORD_SIZE, 32, signed element and result width.
- LANES, 4, multiply-accumulates per cycle; power of 2, divides NO_OF_ELEM.
- ACC_WIDTH (localparam), 2*WORD_SIZE+$clog2(NO_OF_ELEM), accumulator width; no internal overflow possible.

Ports:
- clk  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  request a new dot product.
- start_ready  out  1  high when start is accepted this cycle.
- len  in  $clog2(NO_OF_ELEM)+1  number of elements used; sampled with start.
- sat_en  in  1  1 = saturate, 0 = truncate; sampled with start.
- in1  in  NO_OF_ELEM x WORD_SIZE  signed vector 1; sampled with start.
- in2  in  NO_OF_ELEM x WORD_SIZE  signed vector 2; sampled with start.
- out  out  WORD_SIZE  signed result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- overflow  out  1  result did not fit WORD_SIZE; qualified by out_valid.

Behaviour:
- Reset: RESET is asynchronous, active-low; clock is clk. While RESET=0:
  - state=IDLE; out, out_valid, overflow, accumulator and index are all 0.
  - Captured operands are cleared.
  - Applies mid-operation too: any in-flight result is discarded, no out_valid pulse.
- FSM states: IDLE, RUN, DONE.
- start_ready = (state==IDLE) | (state==DONE & out_ready).
- Start accept (start & start_ready at a rising edge):
  - Register in1, in2, sat_en, and eff_len = (len==0) ? 0 : min(len, NO_OF_ELEM).
  - Clear accumulator and index; go to RUN.
- RUN, one beat per cycle:
  - Adds the sum of in1[idx+j]*in2[idx+j] for j = 0..LANES-1 to the accumulator.
  - Lanes with idx+j >= eff_len contribute 0.
  - Products are signed 2*WORD_SIZE, sign-extended to ACC_WIDTH.
  - idx += LANES.
- Beat count B = max(1, ceil(eff_len/LANES)); len=0 yields result 0 after 1 beat.
- On the edge of beat B:
  - out/overflow are loaded from the final sum (accumulator + last beat), out_valid <= 1, go to DONE.
  - Latency: start accepted at edge T0 -> out_valid high after edge T0+B.
- Output conversion:
  - sat_en=1: clamp to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1]; overflow=1 iff clamped.
  - sat_en=0: out = low WORD_SIZE bits; overflow=1 iff upper bits are not a sign extension.
- DONE:
  - out, overflow and out_valid are held stable until out_valid & out_ready.
  - On handshake: out_valid <= 0 and go to IDLE. If start is also high, accept it in the same cycle and go to RUN instead (back-to-back).
  - out keeps its last value after handshake.
- start in RUN, or in DONE without out_ready, is ignored (start_ready=0); inputs are not sampled.
- Input vectors may change freely after accept; only the captured copies are used.

Decomposition:
- Package pe_pkg holds:
  - pe_state_t enum {IDLE, RUN, DONE}.
  - Default parameter constants.
  - An acc_width(word, elems) function.
  - A sat_trunc function returning {overflow, value}.
- One sub-module, mac_lane_tree: combinational; LANES signed multipliers with per-lane enable masks feeding a balanced adder tree; output is ACC_WIDTH.
- The FSM, index, accumulator and output register live in dot_product_pe.

Test Plan:
- All test plan entries use defaults (16/32/4).
- in1[i]=i+1, in2[i]=1, len=16, sat_en=0 -> out=136, overflow=0; out_valid rises exactly 4 cycles after the start edge.
- Same vectors, len=5 -> out=15, B=2. Then len=0 -> out=0 after 1 beat. Then len=31 -> clamped, out=136.
- in1[i]=-3, in2[i]=2, len=16 -> out=0xFFFFFFA0 (-96), overflow=0.
- in1=in2=all 0x7FFFFFFF, len=16:
  - sat_en=1 -> out=0x7FFFFFFF, overflow=1.
  - sat_en=0 -> out=0x00000010, overflow=1.
- Back-pressure:
  - Hold out_ready=0 for 6 cycles; out stays stable, start_ready=0, start pulses are ignored.
  - Then assert out_ready with start and new vectors in the same cycle; the new job is accepted and out_valid drops for B cycles.
- Assert RESET low during beat 2 of a 4-beat job -> out_valid stays 0, out=0, state IDLE.
  - After release, a fresh job of the first scenario still yields 136.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the dot-product processing element.
// Holds the FSM state type, default sizing constants, the accumulator
// width helper, and the saturate/truncate output conversion.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pe_state_t;

    localparam int DEF_NO_OF_ELEM = 16;
    localparam int DEF_WORD_SIZE  = 32;
    localparam int DEF_LANES      = 4;

    // Widest accumulator / result the conversion helper can handle.
    localparam int MAX_ACC  = 128;
    localparam int MAX_WORD = 64;

    // Full products plus enough guard bits that summing every element can never wrap.
    function automatic int acc_width(input int wordSize, input int elems);
        return 2 * wordSize + $clog2(elems);
    endfunction

    // Converts a sign-extended accumulator to a wordSize-bit result.
    // Returns {overflow, value}; value is right-aligned in the low MAX_WORD bits.
    // The truncated value is the low wordSize bits re-sign-extended; the value
    // fits exactly when that round trip reproduces the accumulator.
    function automatic logic [MAX_WORD:0] sat_trunc(input logic signed [MAX_ACC-1:0] acc,
                                                     input int wordSize,
                                                     input logic satEn);
        logic signed [MAX_ACC-1:0] ext;
        logic signed [MAX_ACC-1:0] maxV;
        logic signed [MAX_ACC-1:0] minV;
        logic signed [MAX_ACC-1:0] res;
        logic fits;
        ext  = (acc <<< (MAX_ACC - wordSize)) >>> (MAX_ACC - wordSize);
        fits = (ext == acc);
        maxV = ({{(MAX_ACC-1){1'b0}}, 1'b1} << (wordSize - 1)) - {{(MAX_ACC-1){1'b0}}, 1'b1};
        minV = ~maxV;
        if (satEn && !fits) begin
            res = acc[MAX_ACC-1] ? minV : maxV;
        end else begin
            res = ext;
        end
        return {~fits, res[MAX_WORD-1:0]};
    endfunction

endpackage

// File: rtl/dot_product_pe_mac_lane_tree.sv
// mac_lane_tree: combinational multiply-reduce for one beat.
// Ports:
//   i_a, i_b : LANES signed WORD_SIZE operands
//   i_en     : per-lane enable; a disabled lane contributes zero
//   o_sum    : signed ACC_WIDTH sum of the enabled lane products
module mac_lane_tree
    import pe_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int LANES     = DEF_LANES,
    parameter int ACC_WIDTH = acc_width(DEF_WORD_SIZE, DEF_NO_OF_ELEM)
) (
    input  logic [LANES-1:0][WORD_SIZE-1:0] i_a,
    input  logic [LANES-1:0][WORD_SIZE-1:0] i_b,
    input  logic [LANES-1:0]                i_en,
    output logic signed [ACC_WIDTH-1:0]     o_sum
);

    logic signed [2*WORD_SIZE-1:0] w_prod [LANES];
    // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, root at 0.
    logic signed [ACC_WIDTH-1:0]   w_node [2*LANES-1];

    genvar j;
    genvar n;

    // Operands are sign-extended to the full product width so the multiply is exact.
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            assign w_prod[j] = i_en[j]
                ? $signed({{WORD_SIZE{i_a[j][WORD_SIZE-1]}}, i_a[j]}) *
                  $signed({{WORD_SIZE{i_b[j][WORD_SIZE-1]}}, i_b[j]})
                : '0;
            assign w_node[LANES-1+j] = {{(ACC_WIDTH-2*WORD_SIZE){w_prod[j][2*WORD_SIZE-1]}}, w_prod[j]};
        end
        for (n = 0; n < LANES-1; n++) begin : g_add
            assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
        end
    endgenerate

    assign o_sum = w_node[0];

endmodule

// File: rtl/dot_product_pe.sv
// dot_product_pe: handshaked, length-programmable dot-product engine.
// Captures two signed vectors on start, reduces LANES products per cycle
// into a wide accumulator, then presents a saturated or truncated result.
// Ports:
//   clk, RESET (async, active-low)
//   start / start_ready      : job request handshake
//   len, sat_en, in1, in2    : job parameters, sampled on accept
//   out / out_valid / out_ready / overflow : result handshake
module dot_product_pe
    import pe_pkg::*;
#(
    parameter int NO_OF_ELEM = DEF_NO_OF_ELEM,
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int LANES      = DEF_LANES
) (
    input  logic                                clk,
    input  logic                                RESET,
    input  logic                                start,
    output logic                                start_ready,
    input  logic [$clog2(NO_OF_ELEM):0]         len,
    input  logic                                sat_en,
    input  logic [NO_OF_ELEM-1:0][WORD_SIZE-1:0] in1,
    input  logic [NO_OF_ELEM-1:0][WORD_SIZE-1:0] in2,
    output logic [WORD_SIZE-1:0]                out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                overflow
);

    localparam int ACC_WIDTH = acc_width(WORD_SIZE, NO_OF_ELEM);
    localparam int LEN_W     = $clog2(NO_OF_ELEM) + 1;
    localparam int ELEM_W    = $clog2(NO_OF_ELEM);

    pe_state_t r_state;
    pe_state_t w_nextState;

    logic [NO_OF_ELEM-1:0][WORD_SIZE-1:0] r_in1;
    logic [NO_OF_ELEM-1:0][WORD_SIZE-1:0] r_in2;
    logic                                 r_sat;
    logic [LEN_W-1:0]                     r_len;
    logic [LEN_W-1:0]                     r_idx;
    logic signed [ACC_WIDTH-1:0]          r_acc;

    logic                           w_accept;
    logic                           w_lastBeat;
    logic [LEN_W-1:0]               w_effLen;
    logic [LEN_W:0]                 w_pos [LANES];
    logic [LANES-1:0][WORD_SIZE-1:0] w_laneA;
    logic [LANES-1:0][WORD_SIZE-1:0] w_laneB;
    logic [LANES-1:0]               w_laneEn;
    logic signed [ACC_WIDTH-1:0]    w_treeSum;
    logic signed [ACC_WIDTH-1:0]    w_final;
    logic signed [MAX_ACC-1:0]      w_wide;
    logic [WORD_SIZE-1:0]           w_convOut;
    logic                           w_convOvf;

    // Lengths above the vector size clamp to it; zero stays zero.
    assign w_effLen = (len > LEN_W'(NO_OF_ELEM)) ? LEN_W'(NO_OF_ELEM) : len;

    // Route the current beat's elements to the lanes and mask those past the length.
    always_comb begin
        w_laneA  = '0;
        w_laneB  = '0;
        w_laneEn = '0;
        for (int j = 0; j < LANES; j++) begin
            w_pos[j]    = {1'b0, r_idx} + (LEN_W+1)'(j);
            w_laneA[j]  = r_in1[w_pos[j][ELEM_W-1:0]];
            w_laneB[j]  = r_in2[w_pos[j][ELEM_W-1:0]];
            w_laneEn[j] = (w_pos[j] < {1'b0, r_len});
        end
    end

    // Zero length still takes one beat because index 0 already covers it.
    assign w_lastBeat = (({1'b0, r_idx} + (LEN_W+1)'(LANES)) >= {1'b0, r_len});

    mac_lane_tree #(
        .WORD_SIZE (WORD_SIZE),
        .LANES     (LANES),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_tree (
        .i_a   (w_laneA),
        .i_b   (w_laneB),
        .i_en  (w_laneEn),
        .o_sum (w_treeSum)
    );

    assign w_final   = r_acc + w_treeSum;
    assign w_wide    = {{(MAX_ACC-ACC_WIDTH){w_final[ACC_WIDTH-1]}}, w_final};
    assign w_convOut = WORD_SIZE'(sat_trunc(w_wide, WORD_SIZE, r_sat));
    assign w_convOvf = 1'(sat_trunc(w_wide, WORD_SIZE, r_sat) >> MAX_WORD);

    // State register.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and start handshake; a DONE result being consumed frees the slot in the same cycle.
    always_comb begin
        w_nextState = r_state;
        start_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                w_accept    = start;
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                start_ready = out_ready;
                w_accept    = start & out_ready;
                if (out_ready) begin
                    w_nextState = start ? RUN : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and result register.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_in1     <= '0;
            r_in2     <= '0;
            r_sat     <= 1'b0;
            r_len     <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            r_in1     <= in1;
            r_in2     <= in2;
            r_sat     <= sat_en;
            r_len     <= w_effLen;
            r_idx     <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
        end else if (r_state == RUN) begin
            r_acc <= w_final;
            r_idx <= r_idx + LEN_W'(LANES);
            if (w_lastBeat) begin
                out       <= w_convOut;
                overflow  <= w_convOvf;
                out_valid <= 1'b1;
            end
        end else if (r_state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
